// File: rtl/cordic_iter_engine_if.sv
// Request/response bundle for the iterative CORDIC engine.
// The master side is upstream (drives in_* and out_ready); the engine is the slave.
interface cordic_iter_engine_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned ZW = 20
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic signed [W-1:0]  in_x;
    logic signed [W-1:0]  in_y;
    logic signed [ZW-1:0] in_z;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W+1:0]  out_x;
    logic signed [W+1:0]  out_y;
    logic signed [ZW-1:0] out_z;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z
    );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative circular CORDIC: one micro-rotation per clock, fed by an external
// registered arctan ROM (1-cycle latency). Rotation and vectoring modes, no gain fix-up.
module cordic_iter_engine #(
    parameter int unsigned W     = 16,
    parameter int unsigned ZW    = 20,
    parameter int unsigned ITERS = 16
) (
    input  logic         clock,
    input  logic         reset,
    cordic_iter_engine_if.slave bus,
    output logic [3:0]   table_addr,
    input  logic [16:0]  table_data
);
    localparam int unsigned XW   = W + 2;
    localparam logic [3:0]  LAST = 4'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, PRIME, ITER, DONE} state_t;

    state_t               state;
    logic                 mode_r;
    logic [3:0]           iter_r;
    logic signed [XW-1:0] x_r;
    logic signed [XW-1:0] y_r;
    logic signed [ZW-1:0] z_r;

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [ZW-1:0] ang;
    logic                 dir;
    logic signed [XW-1:0] x_nx;
    logic signed [XW-1:0] y_nx;
    logic signed [ZW-1:0] z_nx;

    assign bus.in_ready = (state == IDLE);

    // One micro-rotation; dir=1 means d=+1.
    always_comb begin
        x_sh = x_r >>> iter_r;
        y_sh = y_r >>> iter_r;
        ang  = ZW'(table_data);
        dir  = mode_r ? y_r[XW-1] : ~z_r[ZW-1];
        x_nx = x_r;
        y_nx = y_r;
        z_nx = z_r;
        if (dir) begin
            x_nx = x_r - y_sh;
            y_nx = y_r + x_sh;
            z_nx = z_r - ang;
        end else begin
            x_nx = x_r + y_sh;
            y_nx = y_r - x_sh;
            z_nx = z_r + ang;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mode_r        <= 1'b0;
            iter_r        <= 4'd0;
            table_addr    <= 4'd0;
            x_r           <= '0;
            y_r           <= '0;
            z_r           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_x     <= '0;
            bus.out_y     <= '0;
            bus.out_z     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r        <= {{2{bus.in_x[W-1]}}, bus.in_x};
                        y_r        <= {{2{bus.in_y[W-1]}}, bus.in_y};
                        z_r        <= bus.in_z;
                        mode_r     <= bus.in_mode;
                        table_addr <= 4'd0;
                        state      <= PRIME;
                    end
                end
                // ROM is registering entry 0 during this cycle.
                PRIME: begin
                    table_addr <= 4'd1;
                    iter_r     <= 4'd0;
                    state      <= ITER;
                end
                ITER: begin
                    x_r        <= x_nx;
                    y_r        <= y_nx;
                    z_r        <= z_nx;
                    table_addr <= iter_r + 4'd2;
                    iter_r     <= iter_r + 4'd1;
                    if (iter_r == LAST) begin
                        bus.out_valid <= 1'b1;
                        bus.out_x     <= x_nx;
                        bus.out_y     <= y_nx;
                        bus.out_z     <= z_nx;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine with a 1-cycle-latency arctan ROM model
// and a bit-exact reference CORDIC.
module tb_cordic_iter_engine;
    localparam int unsigned W  = 16;
    localparam int unsigned ZW = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  table_addr;
    logic [16:0] table_data = '0;
    logic [16:0] rom [16];

    int n_tests = 0;
    int n_fail  = 0;

    cordic_iter_engine_if #(.W(W), .ZW(ZW)) bus ();

    cordic_iter_engine #(.W(W), .ZW(ZW), .ITERS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .table_addr (table_addr),
        .table_data (table_data)
    );

    always #5 clock = ~clock;

    // round(atan(2^-i) * 2^17)
    initial begin
        rom[0]  = 17'd102944; rom[1]  = 17'd60771; rom[2]  = 17'd32110; rom[3]  = 17'd16299;
        rom[4]  = 17'd8181;   rom[5]  = 17'd4095;  rom[6]  = 17'd2048;  rom[7]  = 17'd1024;
        rom[8]  = 17'd512;    rom[9]  = 17'd256;   rom[10] = 17'd128;   rom[11] = 17'd64;
        rom[12] = 17'd32;     rom[13] = 17'd16;    rom[14] = 17'd8;     rom[15] = 17'd4;
    end

    always @(posedge clock) table_data <= rom[table_addr];

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic golden(input logic m, input logic signed [W-1:0] xi, input logic signed [W-1:0] yi,
                          input logic signed [ZW-1:0] zi, output logic signed [W+1:0] xo,
                          output logic signed [W+1:0] yo, output logic signed [ZW-1:0] zo);
        logic signed [W+1:0]  x, y, xs, ys;
        logic signed [ZW-1:0] z, a;
        logic                 d;
        x = {{2{xi[W-1]}}, xi};
        y = {{2{yi[W-1]}}, yi};
        z = zi;
        for (int i = 0; i < 16; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            a  = {3'b000, rom[i]};
            d  = m ? (y < 0) : (z >= 0);
            if (d) begin
                x = x - ys; y = y + xs; z = z - a;
            end else begin
                x = x + ys; y = y - xs; z = z + a;
            end
        end
        xo = x; yo = y; zo = z;
    endtask

    // One full transaction; stall>0 holds out_ready low and pokes in_valid meanwhile.
    task automatic run(input string tag, input logic m, input logic signed [W-1:0] xi,
                       input logic signed [W-1:0] yi, input logic signed [ZW-1:0] zi, input int stall,
                       output longint rx, output longint ry, output longint rz);
        logic signed [W+1:0]  ex, ey;
        logic signed [ZW-1:0] ez;
        int lat = -1;
        int addr_bad = 0;
        int unstable = 0;
        int busy_ready = 0;
        golden(m, xi, yi, zi, ex, ey, ez);
        bus.in_mode  = m;
        bus.in_x     = xi;
        bus.in_y     = yi;
        bus.in_z     = zi;
        bus.in_valid = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 1) begin
                bus.in_valid = 1'b0;
                bus.in_mode  = ~m;
                bus.in_x     = 16'sh1234;
                bus.in_y     = -16'sh0777;
                bus.in_z     = 20'sh4000;
            end
            if (cyc <= 16 && table_addr != 4'(cyc - 1)) addr_bad++;
            if (bus.out_valid) begin
                lat = cyc - 1;
                break;
            end
        end
        check({tag, "_latency"}, lat, 17);
        check({tag, "_addr_seq_errs"}, addr_bad, 0);
        rx = bus.out_x; ry = bus.out_y; rz = bus.out_z;
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = s[0];
            @(posedge clock); #1;
            if (bus.out_x != ex || bus.out_y != ey || bus.out_z != ez || !bus.out_valid) unstable++;
            if (bus.in_ready) busy_ready++;
        end
        bus.in_valid = 1'b0;
        if (stall > 0) begin
            check({tag, "_stall_unstable"}, unstable, 0);
            check({tag, "_stall_in_ready"}, busy_ready, 0);
        end
        check({tag, "_x"}, bus.out_x, ex);
        check({tag, "_y"}, bus.out_y, ey);
        check({tag, "_z"}, bus.out_z, ez);
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check({tag, "_post_out_valid"}, bus.out_valid, 0);
        check({tag, "_post_in_ready"}, bus.in_ready, 1);
        if (stall > 0) begin
            @(posedge clock); #1;
            check({tag, "_no_spurious_start"}, bus.in_ready, 1);
        end
    endtask

    initial begin
        longint rx, ry, rz;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_z      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_x", bus.out_x, 0);
        check("rst_out_z", bus.out_z, 0);
        check("rst_addr", table_addr, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        run("rot0", 1'b0, 16'sd16384, 16'sd0, 20'sd0, 0, rx, ry, rz);
        check("rot0_x_tol", absl(rx - 26981) <= 4, 1);
        check("rot0_y_tol", absl(ry) <= 4, 1);
        check("rot0_z_tol", absl(rz) <= 16, 1);

        run("rot45", 1'b0, 16'sd16384, 16'sd0, 20'sh19220, 0, rx, ry, rz);
        check("rot45_x_tol", absl(rx - 19079) <= 4, 1);
        check("rot45_y_tol", absl(ry - 19079) <= 4, 1);
        check("rot45_z_tol", absl(rz) <= 16, 1);

        run("vec45", 1'b1, 16'sd16384, 16'sd16384, 20'sd0, 0, rx, ry, rz);
        check("vec45_x_tol", absl(rx - 38155) <= 6, 1);
        check("vec45_y_tol", absl(ry) <= 4, 1);
        check("vec45_z_tol", absl(rz - 102944) <= 16, 1);

        run("rotneg", 1'b0, -16'sd10000, 16'sd5000, -20'sh10000, 0, rx, ry, rz);
        run("vecneg", 1'b1, 16'sd20000, -16'sd12000, 20'sd0, 0, rx, ry, rz);
        run("rotmax", 1'b0, 16'sd32767, 16'sd32767, 20'sd0, 10, rx, ry, rz);

        // Reset while iteration 7 is due (edge E9 after acceptance at E0).
        bus.in_mode  = 1'b0;
        bus.in_x     = 16'sd16384;
        bus.in_y     = 16'sd0;
        bus.in_z     = 20'sh19220;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_x", bus.out_x, 0);
        check("midrst_out_y", bus.out_y, 0);
        check("midrst_out_z", bus.out_z, 0);
        run("after_rst", 1'b1, 16'sd3000, -16'sd4000, 20'sd0, 0, rx, ry, rz);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
